// File: rtl/dt_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dt_scan_ctrl_pkg
// Brief    : Shared display constants (hex 7-segment table) and clog2 helper
// Revision : 1.0 - initial release
// ============================================================================
package dt_scan_ctrl_pkg;

  // Active-high segment patterns {g,f,e,d,c,b,a} for hex digits 0..F
  localparam logic [6:0] c_seg_table [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic int f_clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dt_seg_lut.sv
`default_nettype none
// ============================================================================
// Module   : dt_seg_lut
// Brief    : Combinational hex nibble to active-high 7-segment lookup
// Revision : 1.0 - initial release
// ============================================================================
module dt_seg_lut
  import dt_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = c_seg_table[i_nibble];

endmodule
`default_nettype wire

// File: rtl/dt_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dt_scan_ctrl
// Brief    : Multiplexed 7-segment scan controller with frame-aligned updates
// Revision : 1.0 - initial release
// ============================================================================
module dt_scan_ctrl
  import dt_scan_ctrl_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 100000,
  parameter int LZ_BLANK       = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [4*DIGITS-1:0]         num_in,
  input  logic                        load,
  output logic [DIGITS-1:0]           ds,
  output logic [f_clog2(DIGITS)-1:0]  sel,
  output logic [3:0]                  num,
  output logic [6:0]                  dt,
  output logic                        blank,
  output logic                        pending,
  output logic                        frame_done
);

  localparam int c_sel_w = f_clog2(DIGITS);
  localparam int c_cnt_w = (SCAN_DIV > 1) ? f_clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(SCAN_DIV - 1);
  localparam logic [c_sel_w-1:0] c_idx_max = c_sel_w'(DIGITS - 1);
  localparam logic [6:0]         c_seg_pol = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0]  c_sel_pol = {DIGITS{(SEL_ACTIVE_LOW != 0)}};

  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_sel_w-1:0]  r_idx;
  logic [4*DIGITS-1:0] r_shadow;
  logic [4*DIGITS-1:0] r_display;
  logic                r_pending;
  logic                r_frame_done;

  logic                w_tick;
  logic                w_boundary;
  logic [DIGITS-1:0]   w_zero_above;
  logic [DIGITS-1:0]   w_onehot;
  logic [3:0]          w_cur_nib;
  logic                w_cur_zero;
  logic                w_blank;
  logic [6:0]          w_seg;

  assign w_tick     = (r_cnt == c_cnt_max);
  assign w_boundary = w_tick && (r_idx == c_idx_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + c_sel_w'(1);
    end else begin
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

  // Display only changes at a frame boundary, so a scanned frame never mixes values
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow     <= '0;
      r_display    <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (load) begin
        r_shadow <= num_in;
        if (w_boundary) begin
          r_display    <= num_in;
          r_pending    <= 1'b0;
          r_frame_done <= 1'b1;
        end else begin
          r_pending <= 1'b1;
        end
      end else if (w_boundary && r_pending) begin
        r_display    <= r_shadow;
        r_pending    <= 1'b0;
        r_frame_done <= 1'b1;
      end
    end
  end

  // w_zero_above[i]: nibbles i..DIGITS-1 of the display are all zero
  always_comb begin
    logic acc;
    acc          = 1'b1;
    w_zero_above = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc             = acc & (r_display[4*i +: 4] == 4'h0);
      w_zero_above[i] = acc;
    end
  end

  always_comb begin
    w_cur_nib  = 4'h0;
    w_cur_zero = 1'b0;
    w_onehot   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == c_sel_w'(i)) begin
        w_cur_nib   = r_display[4*i +: 4];
        w_cur_zero  = w_zero_above[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  assign w_blank = (LZ_BLANK != 0) && (r_idx != '0) && w_cur_zero;

  dt_seg_lut u_seg_lut (
    .i_nibble (w_cur_nib),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ds    <= c_sel_pol ^ DIGITS'(1);
      sel   <= '0;
      num   <= 4'h0;
      dt    <= c_seg_table[0] ^ c_seg_pol;
      blank <= 1'b0;
    end else begin
      ds    <= c_sel_pol ^ w_onehot;
      sel   <= r_idx;
      num   <= w_cur_nib;
      dt    <= w_blank ? c_seg_pol : (w_seg ^ c_seg_pol);
      blank <= w_blank;
    end
  end

  assign pending    = r_pending;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dt_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dt_scan_ctrl
// Brief    : Self-checking bench: cycle-count reference model plus directed pins
// Revision : 1.0 - initial release
// ============================================================================
module tb_dt_scan_ctrl;

  localparam int D  = 8;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] num_in = '0;
  logic        load = 1'b0;
  logic [7:0]  ds;
  logic [2:0]  sel;
  logic [3:0]  num;
  logic [6:0]  dt;
  logic        blank, pending, frame_done;

  logic        reset2 = 1'b1;
  logic [7:0]  num_in2 = '0;
  logic        load2 = 1'b0;
  logic [1:0]  ds2;
  logic [0:0]  sel2;
  logic [3:0]  num2;
  logic [6:0]  dt2;
  logic        blank2, pending2, frame_done2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dt_scan_ctrl #(.DIGITS(D), .SCAN_DIV(SD), .LZ_BLANK(1), .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .num_in(num_in), .load(load), .ds(ds), .sel(sel), .num(num),
    .dt(dt), .blank(blank), .pending(pending), .frame_done(frame_done));

  dt_scan_ctrl #(.DIGITS(2), .SCAN_DIV(1)) dut2 (
    .clk(clk), .reset(reset2), .num_in(num_in2), .load(load2), .ds(ds2), .sel(sel2), .num(num2),
    .dt(dt2), .blank(blank2), .pending(pending2), .frame_done(frame_done2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference segment patterns, active-high
  logic [6:0] seg_ref [16];
  initial begin
    seg_ref = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  end

  // Model: position in the scan is derived from cycles elapsed since reset
  int          m_n = 0;
  bit          m_valid = 0;
  logic [31:0] m_disp = '0, m_shadow = '0;
  bit          m_pend = 0;
  logic [2:0]  e_sel;
  logic [3:0]  e_num;
  logic [6:0]  e_dt;
  logic [7:0]  e_ds;
  bit          e_blank, e_pend, e_fd;

  task automatic model_step();
    int  idx;
    bit  bnd, commit;
    m_valid = 1;
    if (reset) begin
      m_n = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
      e_sel = 0; e_num = 0; e_dt = ~seg_ref[0]; e_ds = 8'hFE;
      e_blank = 0; e_pend = 0; e_fd = 0;
    end else begin
      idx = (m_n / SD) % D;
      bnd = (m_n % (SD * D)) == (SD * D - 1);
      e_sel   = 3'(idx);
      e_num   = 4'((m_disp >> (4 * idx)) & 32'hF);
      e_blank = (idx != 0) && ((m_disp >> (4 * idx)) == 0);
      e_dt    = e_blank ? 7'h7F : ~seg_ref[e_num];
      e_ds    = ~(8'(1) << idx);
      commit  = 0;
      if (load) begin
        m_shadow = num_in;
        if (bnd) begin m_disp = num_in; m_pend = 0; commit = 1; end
        else m_pend = 1;
      end else if (bnd && m_pend) begin
        m_disp = m_shadow; m_pend = 0; commit = 1;
      end
      e_pend = m_pend;
      e_fd   = commit;
      m_n++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("sel", 32'(sel), 32'(e_sel));
      chk("num", 32'(num), 32'(e_num));
      chk("dt", 32'(dt), 32'(e_dt));
      chk("ds", 32'(ds), 32'(e_ds));
      chk("blank", 32'(blank), 32'(e_blank));
      chk("pending", 32'(pending), 32'(e_pend));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input int ph);
    int k;
    k = 0;
    while ((m_n % (SD * D)) != ph && k < 100) begin tick(); k++; end
    chk("phase_timeout", 32'(k < 100), 32'd1);
  endtask

  task automatic wait_sel(input int s, output bit ok);
    int k;
    ok = 0;
    for (k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (sel == 3'(s)) ok = 1;
    end
    chk("sel_timeout", 32'(ok), 32'd1);
  endtask

  task automatic load_now(input logic [31:0] v);
    load = 1; num_in = v; tick(); load = 0;
  endtask

  initial begin
    bit ok;
    int fdc, hi, bad;
    logic [0:0] p;
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_ds", 32'(ds), 32'hFE);
    chk("rst_dt", 32'(dt), 32'h40);
    wait_sel(3, ok);
    if (ok) chk("ds_digit3", 32'(ds), 32'hF7);

    // Mid-frame load then frame-aligned commit
    tick(); wait_phase(10);
    load_now(32'h12345678);
    @(negedge clk);
    chk("pend_after_load", 32'(pending), 32'd1);
    fdc = 0;
    repeat (40) begin @(negedge clk); if (frame_done) fdc++; end
    chk("fd_count_1", 32'(fdc), 32'd1);
    wait_sel(0, ok);
    if (ok) begin chk("d0_num", 32'(num), 32'd8); chk("d0_dt", 32'(dt), 32'h00); end

    // Leading-zero blanking
    tick(); wait_phase(5);
    load_now(32'h000000A0);
    repeat (40) @(negedge clk);
    wait_sel(1, ok);
    if (ok) begin chk("a0_d1_num", 32'(num), 32'hA); chk("a0_d1_dt", 32'(dt), 32'h08); end
    wait_sel(2, ok);
    if (ok) begin chk("a0_d2_blank", 32'(blank), 32'd1); chk("a0_d2_dt", 32'(dt), 32'h7F); end
    wait_sel(0, ok);
    if (ok) begin chk("a0_d0_blank", 32'(blank), 32'd0); chk("a0_d0_dt", 32'(dt), 32'h40); end

    // Overwrite before commit
    tick(); wait_phase(3);
    load_now(32'h11111111);
    tick();
    load_now(32'h22222222);
    fdc = 0; bad = 0;
    repeat (70) begin
      @(negedge clk);
      if (frame_done) fdc++;
      if (num == 4'h1) bad++;
    end
    chk("overwrite_fd", 32'(fdc), 32'd1);
    chk("overwrite_no1", 32'(bad), 32'd0);

    // Load exactly on the boundary cycle
    tick(); wait_phase(31);
    load_now(32'h9ABCDEF0);
    fdc = 0; hi = 0;
    @(negedge clk);
    if (frame_done) fdc++;
    if (pending) hi++;
    repeat (40) begin @(negedge clk); if (frame_done) fdc++; if (pending) hi++; end
    chk("aligned_fd", 32'(fdc), 32'd1);
    chk("aligned_pend", 32'(hi), 32'd0);

    // Reset discards a pending value
    tick(); wait_phase(12);
    load_now(32'h87654321);
    reset = 1; tick(); reset = 0;
    @(negedge clk);
    chk("rst_pend", 32'(pending), 32'd0);
    bad = 0;
    repeat (40) begin @(negedge clk); if (num != 4'h0) bad++; end
    chk("rst_display0", 32'(bad), 32'd0);

    // Randomized traffic
    for (int c = 0; c < 2500; c++) begin
      int k;
      logic [63:0] msk;
      tick();
      k = $urandom_range(0, 8);
      msk = (64'd1 << (4 * k)) - 1;
      num_in = 32'($urandom) & 32'(msk);
      load = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    tick(); load = 0; reset = 0;
    repeat (3) tick();

    // Two digits, tick every cycle
    reset2 = 0;
    @(negedge clk);
    @(negedge clk);
    p = sel2;
    repeat (10) begin
      @(negedge clk);
      chk("d2_toggle", 32'(sel2 != p), 32'd1);
      p = sel2;
    end
    tick();
    load2 = 1; num_in2 = 8'h3C; tick(); load2 = 0;
    fdc = 0;
    repeat (3) begin @(negedge clk); if (frame_done2) fdc++; end
    chk("d2_fd", 32'(fdc), 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("d2_num", 32'(num2), (sel2 == 1'b0) ? 32'hC : 32'h3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dt_scan_ctrl.md
DT_SCAN_CTRL -- requirements
Module: dt_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (legal 2..16).
REQ-002 SHALL have parameter SCAN_DIV, default 100000, clk cycles per digit slot (legal >=1).
REQ-003 SHALL have parameter LZ_BLANK, default 1, leading-zero blanking enable.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1, segment output polarity.
REQ-005 SHALL have parameter SEL_ACTIVE_LOW, default 1, digit-select polarity.
REQ-006 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port num_in  input  4*DIGITS  hex value; nibble i drives digit i, and nibble 0 is the least significant.
REQ-009 SHALL have port load  input  1  one-cycle strobe that captures num_in.
REQ-010 SHALL have port ds  output  DIGITS  one-hot digit select, polarity per SEL_ACTIVE_LOW.
REQ-011 SHALL have port sel  output  clog2(DIGITS)  index of the active digit.
REQ-012 SHALL have port num  output  4  nibble of the active digit.
REQ-013 SHALL have port dt  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-014 SHALL have port blank  output  1  active digit is blanked.
REQ-015 SHALL have port pending  output  1  captured value not yet displayed.
REQ-016 SHALL have port frame_done  output  1  one-cycle pulse when a new value is committed.

Function
REQ-017 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert the internal tick when count==SCAN_DIV-1; with SCAN_DIV=1, tick SHALL be asserted every cycle.
REQ-018 On tick, digit index SHALL increment; it SHALL wrap from DIGITS-1 to 0.
REQ-019 A frame boundary SHALL be defined as tick while index==DIGITS-1.
REQ-020 load without a frame boundary SHALL set shadow<=num_in and pending<=1; a later load before commit SHALL overwrite shadow.
REQ-021 At a frame boundary with pending=1 and no load, display SHALL be set to shadow, pending cleared to 0, and frame_done pulsed for 1 cycle.
REQ-022 load coincident with a frame boundary SHALL set display<=num_in and shadow<=num_in, clear pending, and pulse frame_done.
REQ-023 A frame boundary with pending=0 and no load SHALL leave display unchanged and SHALL NOT pulse frame_done.
REQ-024 The display register SHALL be the only source of shown data; no frame SHALL mix old and new nibbles.
REQ-025 Digit i>0 SHALL be blanked when LZ_BLANK=1 and display nibbles i..DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-026 When a digit is blanked, dt SHALL be all segments inactive and blank=1; num SHALL still show the nibble (0).
REQ-027 Segment map SHALL cover hex 0-F, active-high form: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; this SHALL be inverted when SEG_ACTIVE_LOW=1.
REQ-028 ds, sel, num, dt and blank SHALL be registered; each SHALL reflect the index and display state of the previous cycle (1-cycle latency).
REQ-029 ds SHALL have exactly one active bit at all times, including during and after reset.

Reset
REQ-030 While reset=1, prescaler count, index, shadow, display, pending and frame_done SHALL be 0.
REQ-031 The cycle after a reset cycle, outputs SHALL be sel=0, digit 0 active in ds, num=0, dt=pattern "0" (3F, inverted if SEG_ACTIVE_LOW), blank=0, pending=0 and frame_done=0.
REQ-032 Reset SHALL override load and tick in the same cycle; a pending value SHALL be discarded on reset.

Structure
REQ-033 The segment constant table and the clog2 helper SHALL live in a shared display package used with dt_encoder-class blocks.
REQ-034 One sub-module, dt_seg_lut (4-bit nibble -> 7-bit active-high segments, combinational), SHALL be instantiated; polarity and blanking SHALL be applied in dt_scan_ctrl.

Verification (DIGITS=8, SCAN_DIV=4, default polarities)
REQ-035 Reset release -> sel increments every 4 cycles and wraps 7->0; ds is active-low one-hot (digit 0 = FE), digit 3 = F7.
REQ-036 load num_in=32'h12345678 mid-frame -> pending=1; at the next boundary, frame_done pulses once, pending=0, and digit0 num=8, dt=~7F, then 7,6,...,1 in later slots.
REQ-037 load 32'h0000_00A0 -> digits 2..7 have blank=1 and dt=7F; digit1 shows A (dt=~77); digit0 shows 0 (blank=0).
REQ-038 Two loads (32'h11111111, then 32'h22222222) before a boundary -> only 2s are ever displayed; a single frame_done.
REQ-039 load aligned with the frame-boundary cycle -> commits immediately and pending is never observed high; reset asserted while pending=1 -> display returns to 0 and pending is cleared.
REQ-040 SCAN_DIV=1 and DIGITS=2 -> sel toggles every cycle; every other cycle is a boundary.
